// File: rtl/clk_sel_ctrl.sv
// rtl/clk_sel_ctrl.sv - sequences the PLL-enable / clock-select handover and falls back to clk0 on lock loss
module clk_sel_ctrl #(
    parameter int LOCK_STABLE  = 64,
    parameter int LOCK_TIMEOUT = 4096,
    parameter int SWITCH_WAIT  = 16,
    parameter int CNT_W        = 13
) (
    input  logic clk0,
    input  logic rst_n,
    input  logic i_req_pll,
    input  logic i_pll_lock,
    output logic o_pll_en,
    output logic o_sel_clk,
    output logic o_busy,
    output logic o_on_pll,
    output logic o_lock_lost,
    output logic o_lock_fail
);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_WAIT_LOCK = 3'd1,
        ST_SW_TO_PLL = 3'd2,
        ST_ON_PLL    = 3'd3,
        ST_SW_TO_REF = 3'd4,
        ST_FAIL      = 3'd5
    } state_t;

    localparam logic [CNT_W-1:0] LP_STABLE_LAST  = CNT_W'(LOCK_STABLE - 1);
    localparam logic [CNT_W-1:0] LP_TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] LP_SWITCH_LAST  = CNT_W'(SWITCH_WAIT - 1);
    localparam logic [CNT_W-1:0] LP_ONE          = CNT_W'(1);

    state_t           r_state;
    state_t           w_next;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_next;
    logic [CNT_W-1:0] r_scnt;
    logic [CNT_W-1:0] w_scnt_next;
    logic             r_lock_meta;
    logic             r_lock_s;
    logic             w_lost;
    logic             w_fail;
    logic             w_pll_en;
    logic             w_sel_clk;
    logic             w_busy;
    logic             w_on_pll;

    // All outputs are flops so sel_clk can never glitch into the clock switch.
    always_ff @(posedge clk0 or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_scnt      <= '0;
            r_lock_meta <= 1'b0;
            r_lock_s    <= 1'b0;
            o_pll_en    <= 1'b0;
            o_sel_clk   <= 1'b0;
            o_busy      <= 1'b0;
            o_on_pll    <= 1'b0;
            o_lock_lost <= 1'b0;
            o_lock_fail <= 1'b0;
        end else begin
            r_state     <= w_next;
            r_cnt       <= w_cnt_next;
            r_scnt      <= w_scnt_next;
            r_lock_meta <= i_pll_lock;
            r_lock_s    <= r_lock_meta;
            o_pll_en    <= w_pll_en;
            o_sel_clk   <= w_sel_clk;
            o_busy      <= w_busy;
            o_on_pll    <= w_on_pll;
            o_lock_lost <= w_lost;
            o_lock_fail <= w_fail;
        end
    end

    always_comb begin
        w_next      = r_state;
        w_cnt_next  = '0;
        w_scnt_next = '0;
        w_lost      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (i_req_pll) w_next = ST_WAIT_LOCK;
            end
            ST_WAIT_LOCK: begin
                w_cnt_next  = r_cnt + LP_ONE;
                w_scnt_next = r_lock_s ? (r_scnt + LP_ONE) : '0;
                // Stability is checked before timeout so a lock that qualifies on the last cycle still wins.
                if (!i_req_pll)                                 w_next = ST_IDLE;
                else if (r_lock_s && (r_scnt == LP_STABLE_LAST)) w_next = ST_SW_TO_PLL;
                else if (r_cnt == LP_TIMEOUT_LAST)               w_next = ST_FAIL;
            end
            ST_SW_TO_PLL: begin
                w_cnt_next = r_cnt + LP_ONE;
                if (!r_lock_s) begin
                    w_next = ST_SW_TO_REF;
                    w_lost = 1'b1;
                end else if (r_cnt == LP_SWITCH_LAST) begin
                    w_next = ST_ON_PLL;
                end
            end
            ST_ON_PLL: begin
                if (!r_lock_s) begin
                    w_next = ST_SW_TO_REF;
                    w_lost = 1'b1;
                end else if (!i_req_pll) begin
                    w_next = ST_SW_TO_REF;
                end
            end
            ST_SW_TO_REF: begin
                w_cnt_next = r_cnt + LP_ONE;
                if (r_cnt == LP_SWITCH_LAST) w_next = ST_IDLE;
            end
            ST_FAIL: begin
                if (!i_req_pll) w_next = ST_IDLE;
            end
            default: w_next = ST_IDLE;
        endcase

        if (w_next != r_state) begin
            w_cnt_next  = '0;
            w_scnt_next = '0;
        end

        w_fail    = (r_state == ST_WAIT_LOCK) && (w_next == ST_FAIL);
        // The PLL stays enabled through SW_TO_REF so the switch still sees clk1 edges while handing back.
        w_pll_en  = (w_next == ST_WAIT_LOCK) || (w_next == ST_SW_TO_PLL) ||
                    (w_next == ST_ON_PLL)    || (w_next == ST_SW_TO_REF);
        w_sel_clk = (w_next == ST_SW_TO_PLL) || (w_next == ST_ON_PLL);
        w_busy    = (w_next == ST_WAIT_LOCK) || (w_next == ST_SW_TO_PLL) ||
                    (w_next == ST_SW_TO_REF);
        w_on_pll  = (w_next == ST_ON_PLL);
    end

endmodule
